keccak_msg_framer: RTL and testbench

//   Upstream feeder for the Keccak IP. Accepts a byte stream with end-of-message marker,

---
 rtl/keccak_msg_framer.sv | 187 ++++++++++++++++++
 tb/tb_keccak_msg_framer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_msg_framer.sv
// keccak_msg_framer: collects one byte-stream message into a word buffer, then
// emits the parameter element {digest_bits, byte_count} followed by the packed
// 64-bit data words. The Keccak IP needs the byte count before any data word,
// so the whole message is held until its last byte arrives.
// Optional feature: define KECCAK_FRAMER_STATS_EN to add the msg_count output
// (parms handshakes since reset, wrapping at 2^32).
module keccak_msg_framer #(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_W       = 32
) (
  input  logic        Clk40,
  input  logic        reset_n,
  input  logic        in_byte_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_byte_last,
  input  logic        in_byte_empty,
  input  logic        in_mode_512,
  output logic        in_byte_ready,
  output logic        out_parms_valid,
  output logic [63:0] out_parms_element,
  input  logic        out_parms_ready,
  output logic        out_data_valid,
  output logic [63:0] out_data_element,
  input  logic        out_data_ready,
`ifdef KECCAK_FRAMER_STATS_EN
  output logic [31:0] msg_count,
`endif
  output logic        overflow
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PW = AW + 1;
  localparam logic [CNT_W-1:0] MAX_BYTES = CNT_W'(DEPTH_WORDS * 8);

  typedef enum logic [1:0] {COLLECT, PARMS, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pack_q, pack_d;
  logic [63:0]      data_q, data_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             mode_q, mode_d;
  logic             ov_q, ov_d;
  logic             first_q, first_d;
  logic             rdy_q, pv_q, dv_q;

  logic [63:0]      mem [DEPTH_WORDS];
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [63:0]      wr_data;

  logic             hs_in, hs_parms, hs_data, marker, full, take;
  logic [63:0]      merged;
  logic [PW-1:0]    nwords;

  // ready/valid registers already encode the state, so handshakes need no decode
  assign hs_in    = in_byte_valid & rdy_q;
  assign hs_parms = pv_q & out_parms_ready;
  assign hs_data  = dv_q & out_data_ready;
  assign marker   = in_byte_last & in_byte_empty;
  assign full     = (cnt_q == MAX_BYTES);
  assign take     = hs_in & ~marker & ~full;
  assign merged   = pack_q | ({56'd0, in_byte} << {cnt_q[2:0], 3'b000});
  assign nwords   = PW'((cnt_q + CNT_W'(7)) >> 3);
  assign wr_addr  = AW'(cnt_q >> 3);

  // next-state: pack and store bytes, close message, then walk the buffer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    data_d  = data_q;
    rptr_d  = rptr_q;
    mode_d  = mode_q;
    ov_d    = ov_q;
    first_d = first_q;
    wr_en   = 1'b0;
    wr_data = merged;
    case (state_q)
      COLLECT: begin
        if (hs_in) begin
          first_d = 1'b0;
          if (first_q) ov_d = 1'b0;
          if (!marker && full) ov_d = 1'b1;
          if (take) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q[2:0] == 3'd7 || in_byte_last) begin
              wr_en  = 1'b1;
              pack_d = '0;
            end else begin
              pack_d = merged;
            end
          end else if (in_byte_last && cnt_q[2:0] != 3'd0) begin
            // trailing marker or dropped last byte: flush the partial word
            wr_en   = 1'b1;
            wr_data = pack_q;
            pack_d  = '0;
          end
          if (in_byte_last) begin
            mode_d  = in_mode_512;
            state_d = PARMS;
          end
        end
      end
      PARMS: begin
        if (hs_parms) begin
          if (cnt_q == '0) begin
            state_d = COLLECT;
            first_d = 1'b1;
          end else begin
            // word 0 is loaded on this edge so data is valid the next cycle
            state_d = DRAIN;
            data_d  = mem[0];
            rptr_d  = PW'(1);
          end
        end
      end
      DRAIN: begin
        if (hs_data) begin
          if (rptr_q == nwords) begin
            state_d = COLLECT;
            cnt_d   = '0;
            data_d  = '0;
            rptr_d  = '0;
            first_d = 1'b1;
          end else begin
            data_d = mem[rptr_q[AW-1:0]];
            rptr_d = rptr_q + PW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // state and output registers; ready/valid follow the next state
  always_ff @(posedge Clk40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      rptr_q  <= '0;
      mode_q  <= 1'b0;
      ov_q    <= 1'b0;
      first_q <= 1'b1;
      rdy_q   <= 1'b0;
      pv_q    <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      rptr_q  <= rptr_d;
      mode_q  <= mode_d;
      ov_q    <= ov_d;
      first_q <= first_d;
      rdy_q   <= (state_d == COLLECT);
      pv_q    <= (state_d == PARMS);
      dv_q    <= (state_d == DRAIN);
    end
  end

  // message buffer, no reset needed: contents are only read after being written
  always_ff @(posedge Clk40) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef KECCAK_FRAMER_STATS_EN
  logic [31:0] msg_cnt_q;
  // one count per parms handshake, free-running wrap
  always_ff @(posedge Clk40 or negedge reset_n) begin
    if (!reset_n)      msg_cnt_q <= '0;
    else if (hs_parms) msg_cnt_q <= msg_cnt_q + 32'd1;
  end
  assign msg_count = msg_cnt_q;
`endif

  assign in_byte_ready     = rdy_q;
  assign out_parms_valid   = pv_q;
  assign out_parms_element = pv_q ? {(mode_q ? 32'd512 : 32'd256), 32'(cnt_q)} : 64'd0;
  assign out_data_valid    = dv_q;
  assign out_data_element  = data_q;
  assign overflow          = ov_q;

endmodule

// File: tb/tb_keccak_msg_framer.sv
// Bench for keccak_msg_framer: directed vector table, stall/reset sequences and
// randomized messages checked against a byte-list reference model.
module tb_keccak_msg_framer;
  localparam int DW   = 4;
  localparam int MAXB = DW * 8;

  logic        Clk40, reset_n;
  logic        in_byte_valid, in_byte_last, in_byte_empty, in_mode_512, in_byte_ready;
  logic [7:0]  in_byte;
  logic        out_parms_valid, out_parms_ready, out_data_valid, out_data_ready, overflow;
  logic [63:0] out_parms_element, out_data_element;
`ifdef KECCAK_FRAMER_STATS_EN
  logic [31:0] msg_count;
`endif

  keccak_msg_framer #(.DEPTH_WORDS(DW), .CNT_W(32)) dut (
    .Clk40(Clk40), .reset_n(reset_n),
    .in_byte_valid(in_byte_valid), .in_byte(in_byte), .in_byte_last(in_byte_last),
    .in_byte_empty(in_byte_empty), .in_mode_512(in_mode_512), .in_byte_ready(in_byte_ready),
    .out_parms_valid(out_parms_valid), .out_parms_element(out_parms_element),
    .out_parms_ready(out_parms_ready),
    .out_data_valid(out_data_valid), .out_data_element(out_data_element),
    .out_data_ready(out_data_ready),
`ifdef KECCAK_FRAMER_STATS_EN
    .msg_count(msg_count),
`endif
    .overflow(overflow)
  );

  initial Clk40 = 1'b0;
  always #10 Clk40 = ~Clk40;

  int n_chk  = 0;
  int n_fail = 0;
  int parms_hs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // reference: keep the first MAXB bytes, little-endian pack into 64-bit words
  task automatic model(input logic [7:0] q[$], input bit mode,
                       output logic [63:0] parms, output logic [63:0] w[$]);
    int n;
    logic [63:0] tmp;
    n = (q.size() < MAXB) ? q.size() : MAXB;
    w = {};
    for (int i = 0; i < (n + 7) / 8; i++) w.push_back(64'd0);
    for (int j = 0; j < n; j++) begin
      tmp = w[j / 8];
      tmp = tmp | (64'(q[j]) << (8 * (j % 8)));
      w[j / 8] = tmp;
    end
    parms = {(mode ? 32'd512 : 32'd256), 32'(n)};
  endtask

  task automatic send(input logic [7:0] q[$], input bit tail, input bit mode, input bit gaps);
    int n, tot, t;
    n   = q.size();
    tot = n + ((tail || n == 0) ? 1 : 0);
    for (int j = 0; j < tot; j++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge Clk40); #1; end
      in_byte_valid = 1'b1;
      in_byte       = (j < n) ? q[j] : 8'($urandom);
      in_byte_last  = (j == tot - 1);
      in_byte_empty = (j >= n);
      in_mode_512   = (j == tot - 1) ? mode : 1'($urandom);
      t = 0;
      while (!in_byte_ready && t < 100) begin @(posedge Clk40); #1; t++; end
      chk1("byte_ready", in_byte_ready, 1'b1);
      @(posedge Clk40); #1;
      in_byte_valid = 1'b0; in_byte_last = 1'b0; in_byte_empty = 1'b0;
      if (j < n)      chk1("overflow_byte", overflow, j >= MAXB);
      else if (n > 0) chk1("overflow_close", overflow, n > MAXB);
      if (j == tot - 1) chk1("parms_valid_latency", out_parms_valid, 1'b1);
    end
  endtask

  // stall: 0 continuous ready, 1 alternate stall, 2 random stall
  task automatic recv(input logic [63:0] exp_parms, input logic [63:0] ew[$], input int stall);
    int t;
    bit st;
    t = 0;
    while (!out_parms_valid && t < 100) begin @(posedge Clk40); #1; t++; end
    chk1("parms_valid", out_parms_valid, 1'b1);
    chk("parms_element", out_parms_element, exp_parms);
    chk1("ready_low_in_parms", in_byte_ready, 1'b0);
    if (stall != 0) begin
      @(posedge Clk40); #1;
      chk1("parms_hold_valid", out_parms_valid, 1'b1);
      chk("parms_hold_element", out_parms_element, exp_parms);
    end
    out_parms_ready = 1'b1;
    @(posedge Clk40); #1;
    out_parms_ready = 1'b0;
    parms_hs++;
    chk1("parms_drop", out_parms_valid, 1'b0);
    if (ew.size() == 0) begin
      chk1("empty_no_data", out_data_valid, 1'b0);
      chk1("empty_ready_back", in_byte_ready, 1'b1);
      return;
    end
    for (int i = 0; i < ew.size(); i++) begin
      st = (stall == 1) ? (i % 2 == 0) : (stall == 2) ? 1'($urandom) : 1'b0;
      if (st) begin
        @(posedge Clk40); #1;
        chk("data_hold_element", out_data_element, ew[i]);
      end
      chk1("data_valid", out_data_valid, 1'b1);
      chk("data_element", out_data_element, ew[i]);
      out_data_ready = 1'b1;
      @(posedge Clk40); #1;
      out_data_ready = 1'b0;
    end
    chk1("drain_done_valid", out_data_valid, 1'b0);
    chk1("drain_done_ready", in_byte_ready, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk1({tag, "_ready"}, in_byte_ready, 1'b0);
    chk1({tag, "_pvalid"}, out_parms_valid, 1'b0);
    chk({tag, "_pelem"}, out_parms_element, 64'd0);
    chk1({tag, "_dvalid"}, out_data_valid, 1'b0);
    chk({tag, "_delem"}, out_data_element, 64'd0);
    chk1({tag, "_ovf"}, overflow, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge Clk40); #1;
    reset_n = 1'b1;
    chk1("ready_before_first_edge", in_byte_ready, 1'b0);
    @(posedge Clk40); #1;
    chk1("ready_after_release", in_byte_ready, 1'b1);
  endtask

  typedef struct {
    logic [7:0]  b [40];
    int          len;
    bit          tail;
    bit          mode;
    logic [63:0] exp_parms;
    int          n_words;
    logic [63:0] exp_w [4];
    bit          exp_ov;
    int          stall;
  } vec_t;

  vec_t tv [5];

  task automatic set_str(input int i, input string s);
    tv[i].len = s.len();
    for (int k = 0; k < s.len(); k++) tv[i].b[k] = s[k];
  endtask

  task automatic run_vec(input int i);
    logic [7:0]  q[$];
    logic [63:0] w[$];
    q = {};
    w = {};
    for (int k = 0; k < tv[i].len; k++) q.push_back(tv[i].b[k]);
    for (int k = 0; k < tv[i].n_words; k++) w.push_back(tv[i].exp_w[k]);
    send(q, tv[i].tail, tv[i].mode, 1'b0);
    recv(tv[i].exp_parms, w, tv[i].stall);
    if (tv[i].len > 0) chk1("overflow_after_msg", overflow, tv[i].exp_ov);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [63:0] w[$];
    logic [63:0] p;
    int extra;
    bit md, tl;

    in_byte_valid = 0; in_byte = 0; in_byte_last = 0; in_byte_empty = 0; in_mode_512 = 0;
    out_parms_ready = 0; out_data_ready = 0;
    reset_n = 0;

    for (int i = 0; i < 5; i++) begin
      tv[i].len = 0; tv[i].tail = 0; tv[i].mode = 0; tv[i].exp_parms = 0;
      tv[i].n_words = 0; tv[i].exp_ov = 0; tv[i].stall = 0;
      for (int k = 0; k < 40; k++) tv[i].b[k] = 8'h00;
      for (int k = 0; k < 4; k++)  tv[i].exp_w[k] = 64'd0;
    end
    set_str(0, "As Estha stirred");
    tv[0].exp_parms = 64'h00000100_00000010; tv[0].n_words = 2;
    tv[0].exp_w[0] = 64'h6168747345207341; tv[0].exp_w[1] = 64'h6465727269747320;
    tv[1].tail = 1; tv[1].mode = 1; tv[1].exp_parms = 64'h00000200_00000000;
    set_str(2, "As ");
    tv[2].exp_parms = 64'h00000100_00000003; tv[2].n_words = 1;
    tv[2].exp_w[0] = 64'h0000000000207341;
    tv[3].len = 40; tv[3].mode = 1; tv[3].exp_ov = 1; tv[3].stall = 2;
    for (int k = 0; k < 40; k++) tv[3].b[k] = 8'(k);
    tv[3].exp_parms = 64'h00000200_00000020; tv[3].n_words = 4;
    tv[3].exp_w[0] = 64'h0706050403020100; tv[3].exp_w[1] = 64'h0F0E0D0C0B0A0908;
    tv[3].exp_w[2] = 64'h1716151413121110; tv[3].exp_w[3] = 64'h1F1E1D1C1B1A1918;
    set_str(4, "As ");
    tv[4].tail = 1; tv[4].mode = 1; tv[4].stall = 1;
    tv[4].exp_parms = 64'h00000200_00000003; tv[4].n_words = 1;
    tv[4].exp_w[0] = 64'h0000000000207341;

    repeat (3) @(posedge Clk40);
    #1;
    check_idle_outputs("reset");
    release_reset();

    for (int i = 0; i < 5; i++) run_vec(i);

    // alternating data-ready stalls on a 16-byte message, exactly two words
    q = {};
    for (int k = 0; k < 16; k++) q.push_back(tv[0].b[k]);
    model(q, 1'b0, p, w);
    send(q, 1'b0, 1'b0, 1'b0);
    recv(p, w, 1);
    extra = 0;
    out_data_ready = 1'b1;
    repeat (4) begin @(posedge Clk40); #1; if (out_data_valid) extra++; end
    out_data_ready = 1'b0;
    chk("no_extra_words", 64'(extra), 64'd0);

    // reset asserted while draining: outputs clear at once, then recover
    send(q, 1'b0, 1'b0, 1'b0);
    out_parms_ready = 1'b1;
    @(posedge Clk40); #1;
    out_parms_ready = 1'b0;
    parms_hs++;
    chk1("drain_started", out_data_valid, 1'b1);
    @(posedge Clk40); #3;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    parms_hs = 0;
    release_reset();
    run_vec(0);

    // randomized messages against the reference model
    for (int r = 0; r < 40; r++) begin
      q = {};
      for (int k = 0; k < $urandom_range(0, 40); k++) q.push_back(8'($urandom));
      md = 1'($urandom);
      tl = 1'($urandom);
      model(q, md, p, w);
      send(q, tl, md, 1'b1);
      recv(p, w, 2);
      if (q.size() > 0) chk1("rand_overflow", overflow, q.size() > MAXB);
    end

`ifdef KECCAK_FRAMER_STATS_EN
    chk("msg_count", 64'(msg_count), 64'(parms_hs));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
    $fatal(1, "timeout");
  end

endmodule
